// File: rtl/param_serializer_fsm.sv
// param_serializer_fsm: parallel-to-serial shifter with programmable width,
// bit period (DIV clocks per bit) and shift direction.
// Optional build macro: SERIALIZER_PARITY_EN appends one even-parity bit
// (XOR of the captured word) after the data bits. Left undefined, there is
// no PARITY state and no parity logic.
//
// Handshake: ready=1 only in IDLE. A start sampled high on a rising edge
// while ready=1 captures data_input, and the FSM moves to LOAD. start is
// ignored in every other state. A falling edge on ss, seen while in WAIT,
// starts the shift-out. ss high while sending abandons the frame.
module param_serializer_fsm #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [WIDTH-1:0]               data_input,
  input  logic                           ss,
  output logic                           ready,
  output logic                           busy,
  output logic                           data_output,
  output logic                           data_sent,
  output logic                           aborted,
  output logic [2:0]                     y_Q,
  output logic [$clog2(WIDTH+1)-1:0]     bit_count
);

  localparam int CW = $clog2(WIDTH + 1);
  // With DIV=1 the divider collapses to a constant-zero bit, so it is trimmed away.
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_SEND   = 3'd3,
    S_PARITY = 3'd4
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    div_q;
  logic             ss_q;
  logic             sent_q;
  logic             abort_q;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  logic div_tc;
  logic ss_fall;

  assign div_tc  = (div_q == DIV_LAST);
  assign ss_fall = ss_q & ~ss;

  // Frame sequencing, shift register, bit/divider counters and completion pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      ss_q     <= 1'b1;
      sent_q   <= 1'b0;
      abort_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      ss_q    <= ss;
      sent_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q  <= data_input;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= ^data_input;
`endif
            cnt_q    <= '0;
            div_q    <= '0;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Only a high-to-low transition seen here starts the frame; a level
          // that was already low on entry has to go high and fall again.
          if (ss_fall) begin
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (ss) begin
            // Deselect beats a coincident last-bit terminal count.
            state_q <= S_IDLE;
            abort_q <= 1'b1;
            cnt_q   <= '0;
            div_q   <= '0;
          end else if (div_tc) begin
            div_q <= '0;
            if (MSB_FIRST != 0) begin
              shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            end else begin
              shift_q <= {1'b0, shift_q[WIDTH-1:1]};
            end
            if (cnt_q != FULL_CNT) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_IDLE;
              sent_q  <= 1'b1;
`endif
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
`ifdef SERIALIZER_PARITY_EN
        S_PARITY: begin
          if (ss) begin
            state_q <= S_IDLE;
            abort_q <= 1'b1;
            cnt_q   <= '0;
            div_q   <= '0;
          end else if (div_tc) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            sent_q  <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Serial pin: the bit at the output end of the shift register while sending, else 0.
  always_comb begin
    data_output = 1'b0;
    case (state_q)
      S_SEND: data_output = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: data_output = parity_q;
`endif
      default: data_output = 1'b0;
    endcase
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign data_sent = sent_q;
  assign aborted   = abort_q;
  assign y_Q       = state_q;
  assign bit_count = cnt_q;

endmodule
